// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the iterative forward-cipher engine.
// Holds round count, GF(2^8) reduction constant, FSM encoding and the
// pure ShiftRows / MixColumns transforms on a FIPS column-major 128-bit block.
package aes_pkg;

  localparam int           NR         = 10;
  localparam logic [3:0]   LAST_ROUND = 4'(NR);
  localparam logic [7:0]   GF_POLY    = 8'h1b;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  // Byte i of the block sits at bits [127-8i -: 8], row i%4, column i/4.
  // Row r rotates left by r byte positions.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+row)%4)+row) -: 8];
      end
    end
    return r;
  endfunction

  // Each column multiplied by the circulant {02,03,01,01}.
  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    logic [7:0]   b0, b1, b2, b3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c    -: 8];
      a1 = s[127-32*c-8  -: 8];
      a2 = s[127-32*c-16 -: 8];
      a3 = s[127-32*c-24 -: 8];
      b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      r[127-32*c -: 32] = {b0, b1, b2, b3};
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte, pure combinational lookup.
// Latency: 0 cycles. Backpressure: none (no state).
// Ports: byte_i input byte, byte_o substituted byte.
module aes_sbox (
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign byte_o = SBOX[byte_i];

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryptor: one cipher round per clock, round keys fetched by index.
// Latency: ciphertext valid 10 edges after the accepting edge; at most one block in flight.
// Backpressure: result held in DONE until iReady; oReady stays low from accept to output handshake.
// Ports: clk/rst (sync, active-high); iValid/oReady/iBlockIn plaintext in;
//        oKeyIdx/iKeyValue round-key fetch (combinational return); oValid/iReady/oBlockout ciphertext out.
module aes_encrypt_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         iValid,
  output logic         oReady,
  input  logic [127:0] iBlockIn,
  output logic [3:0]   oKeyIdx,
  input  logic [127:0] iKeyValue,
  output logic         oValid,
  input  logic         iReady,
  output logic [127:0] oBlockout
);

  state_e       fsm_q;
  logic [3:0]   round_q;
  logic [127:0] blk_q;
  logic [127:0] dout_q;
  logic         ready_q;
  logic         valid_q;

  logic [127:0] sub_bytes;
  logic [127:0] shifted;
  logic [127:0] mixed;
  logic [127:0] blk_d;

  // SubBytes: one S-box per state byte.
  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (
      .byte_i (blk_q[127-8*i -: 8]),
      .byte_o (sub_bytes[127-8*i -: 8])
    );
  end

  assign shifted = shift_rows(sub_bytes);
  assign mixed   = mix_columns(shifted);

  // The final round omits MixColumns.
  assign blk_d = ((round_q == LAST_ROUND) ? shifted : mixed) ^ iKeyValue;

  // round_q doubles as the key index: 0 in IDLE/DONE, 1..10 while BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      round_q <= 4'd0;
      blk_q   <= '0;
      dout_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          // ready_q is high throughout IDLE, so iValid alone completes the handshake.
          if (iValid) begin
            blk_q   <= iBlockIn ^ iKeyValue;
            round_q <= 4'd1;
            ready_q <= 1'b0;
            fsm_q   <= BUSY;
          end
        end
        BUSY: begin
          if (round_q == LAST_ROUND) begin
            dout_q  <= blk_d;
            valid_q <= 1'b1;
            round_q <= 4'd0;
            fsm_q   <= DONE;
          end else begin
            blk_q   <= blk_d;
            round_q <= round_q + 4'd1;
          end
        end
        DONE: begin
          if (iReady) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            fsm_q   <= IDLE;
          end
        end
        default: begin
          fsm_q   <= IDLE;
          round_q <= 4'd0;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign oReady    = ready_q;
  assign oValid    = valid_q;
  assign oKeyIdx   = round_q;
  assign oBlockout = dout_q;

endmodule
